// File: rtl/mmff_pkg.sv
// Shared mode encodings and the per-bit next-state function for the multimode flip-flop bank.
package mmff_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_D  = 2'b00;
  localparam mode_t MODE_T  = 2'b01;
  localparam mode_t MODE_JK = 2'b10;
  localparam mode_t MODE_SR = 2'b11;

  // SR with S=R=1 holds the bit; flagging it is left to the caller.
  function automatic logic next_bit(mode_t mode, logic q, logic a, logic b);
    logic nxt;
    nxt = q;
    case (mode)
      MODE_D:  nxt = a;
      MODE_T:  nxt = q ^ a;
      MODE_JK: begin
        case ({a, b})
          2'b01:   nxt = 1'b0;
          2'b10:   nxt = 1'b1;
          2'b11:   nxt = ~q;
          default: nxt = q;
        endcase
      end
      MODE_SR: begin
        case ({a, b})
          2'b01:   nxt = 1'b0;
          2'b10:   nxt = 1'b1;
          default: nxt = q;
        endcase
      end
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mmff_bit_cell.sv
// Single-bit next-state logic plus SR S=R=1 detect; purely combinational.
module mmff_bit_cell
  import mmff_pkg::*;
(
  input  mode_t mode_i,
  input  logic  q_i,
  input  logic  a_i,
  input  logic  b_i,
  output logic  d_o,
  output logic  illegal_o
);

  assign d_o       = next_bit(mode_i, q_i, a_i, b_i);
  assign illegal_o = (mode_i == MODE_SR) && a_i && b_i;

endmodule

// File: rtl/multimode_ff_bank.sv
// WIDTH-bit D/T/JK/SR flip-flop bank with change pulse and sticky SR-illegal flag; 1-cycle latency, no backpressure.
// Optional saturating change counter on toggle_cnt when MMFF_TOGGLE_CNT_EN is defined.
module multimode_ff_bank
  import mmff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             chg,
  output logic             sr_illegal
`ifdef MMFF_TOGGLE_CNT_EN
  ,
  output logic [CNT_W-1:0] toggle_cnt
`endif
);

  if (WIDTH < 1 || WIDTH > 64 || CNT_W < 1) begin : g_bad_param
    $error("multimode_ff_bank: WIDTH must be 1..64 and CNT_W >= 1");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] cell_d, cell_ill;
  logic             chg_q, chg_d;
  logic             ill_q, ill_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    mmff_bit_cell u_cell (
      .mode_i    (mode),
      .q_i       (q_q[i]),
      .a_i       (a[i]),
      .b_i       (b[i]),
      .d_o       (cell_d[i]),
      .illegal_o (cell_ill[i])
    );
  end

  always_comb begin
    q_d   = q_q;
    ill_d = ill_q;
    if (clr) begin
      q_d   = RESET_VAL;
      ill_d = 1'b0;
    end else if (en) begin
      q_d   = cell_d;
      ill_d = ill_q | (|cell_ill);
    end
    chg_d = (q_d != q_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= RESET_VAL;
      chg_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      chg_q <= chg_d;
      ill_q <= ill_d;
    end
  end

  assign q          = q_q;
  assign qbar       = ~q_q;
  assign chg        = chg_q;
  assign sr_illegal = ill_q;

`ifdef MMFF_TOGGLE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // clr wins over a same-edge increment; saturate rather than wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (chg_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign toggle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_multimode_ff_bank.sv
module tb_multimode_ff_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en, clr;
  logic [1:0] mode;
  logic [7:0] a, b;
  logic [7:0] q, qbar;
  logic       chg, sr_illegal;

  logic       en1, clr1;
  logic [1:0] mode1;
  logic       a1, b1;
  logic       q1, qbar1, chg1, ill1;

`ifdef MMFF_TOGGLE_CNT_EN
  logic [1:0] toggle_cnt, toggle_cnt1;
`endif

  multimode_ff_bank #(.WIDTH(8), .RESET_VAL(8'h00), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .a(a), .b(b),
    .q(q), .qbar(qbar), .chg(chg), .sr_illegal(sr_illegal)
`ifdef MMFF_TOGGLE_CNT_EN
    , .toggle_cnt(toggle_cnt)
`endif
  );

  multimode_ff_bank #(.WIDTH(1), .RESET_VAL(1'b0), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .clr(clr1), .mode(mode1), .a(a1), .b(b1),
    .q(q1), .qbar(qbar1), .chg(chg1), .sr_illegal(ill1)
`ifdef MMFF_TOGGLE_CNT_EN
    , .toggle_cnt(toggle_cnt1)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [7:0] m_q;
  logic       m_chg, m_ill;
  int         m_cnt;
  logic       m1_q;

  // Characteristic equations straight from the truth tables.
  function automatic logic [7:0] ref_next(logic [1:0] md, logic [7:0] cq, logic [7:0] ja, logic [7:0] kb);
    case (md)
      2'd0:    return ja;
      2'd1:    return cq ^ ja;
      2'd2:    return (ja & ~cq) | (~kb & cq);
      default: return (ja & ~kb) | (cq & ~(ja ^ kb));
    endcase
  endfunction

  task automatic model_reset();
    m_q = 8'h00; m_chg = 1'b0; m_ill = 1'b0; m_cnt = 0; m1_q = 1'b0;
  endtask

  // Advance one rising edge, updating the reference from the driven inputs.
  task automatic tick();
    logic [7:0] nq;
    logic       n1;
    nq = m_q;
    if (clr) begin
      nq = 8'h00; m_ill = 1'b0;
    end else if (en) begin
      nq = ref_next(mode, m_q, a, b);
      if (mode == 2'd3 && (a & b) != 8'h00) m_ill = 1'b1;
    end
    m_chg = (nq != m_q);
    if (clr) m_cnt = 0;
    else if (m_chg && m_cnt < 3) m_cnt = m_cnt + 1;
    n1 = m1_q;
    if (clr1) n1 = 1'b0;
    else if (en1) n1 = m1_q ^ a1;
    @(posedge clk);
    m_q  = nq;
    m1_q = n1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; mode = 2'd0; a = 8'h00; b = 8'h00;
    en1 = 1'b0; clr1 = 1'b0; mode1 = 2'd1; a1 = 1'b0; b1 = 1'b0;
    model_reset();
    #3;
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", q); end
    checks++; if (qbar !== 8'hFF) begin failures++; $display("FAIL reset_qbar got=%h exp=ff", qbar); end
    checks++; if (chg !== 1'b0 || sr_illegal !== 1'b0) begin failures++; $display("FAIL reset_flags chg=%b ill=%b exp=0,0", chg, sr_illegal); end
    checks++; if (q1 !== 1'b0) begin failures++; $display("FAIL reset_q1 got=%b exp=0", q1); end
`ifdef MMFF_TOGGLE_CNT_EN
    checks++; if (toggle_cnt !== 2'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", toggle_cnt); end
`endif
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_legacy_t();
    logic tpat [0:4];
    tpat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    en1 = 1'b1; mode1 = 2'd1;
    for (int i = 0; i < 25; i++) begin
      a1 = (i < 5) ? tpat[i] : 1'($urandom_range(0, 1));
      tick();
      checks++; if (q1 !== m1_q) begin failures++; $display("FAIL legacy_q step=%0d got=%b exp=%b", i, q1, m1_q); end
      checks++; if (qbar1 !== ~m1_q) begin failures++; $display("FAIL legacy_qbar step=%0d got=%b exp=%b", i, qbar1, ~m1_q); end
    end
    en1 = 1'b0;
  endtask

  task automatic test_d_mode();
    en = 1'b1; mode = 2'd0; a = 8'hA5;
    tick();
    checks++; if (q !== 8'hA5 || chg !== 1'b1) begin failures++; $display("FAIL d_load q=%h chg=%b exp=a5,1", q, chg); end
    tick();
    checks++; if (q !== 8'hA5 || chg !== 1'b0) begin failures++; $display("FAIL d_hold q=%h chg=%b exp=a5,0", q, chg); end
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom);
      tick();
      checks++; if (q !== m_q || chg !== m_chg) begin failures++; $display("FAIL d_rand q=%h chg=%b exp=%h,%b", q, chg, m_q, m_chg); end
    end
  endtask

  task automatic test_jk();
    en = 1'b1; mode = 2'd0; a = 8'h0F;
    tick();
    mode = 2'd2; a = 8'hF0; b = 8'hFF;
    tick();
    checks++; if (q !== 8'hF0) begin failures++; $display("FAIL jk_setreset got=%h exp=f0", q); end
    a = 8'hFF; b = 8'hFF;
    tick();
    checks++; if (q !== 8'h0F) begin failures++; $display("FAIL jk_toggle got=%h exp=0f", q); end
  endtask

  task automatic test_sr_illegal();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (q !== 8'h00 || sr_illegal !== 1'b0) begin failures++; $display("FAIL sr_pre q=%h ill=%b exp=00,0", q, sr_illegal); end
    en = 1'b1; mode = 2'd3; a = 8'h81; b = 8'h01;
    tick();
    checks++; if (q !== 8'h80 || sr_illegal !== 1'b1) begin failures++; $display("FAIL sr_illegal q=%h ill=%b exp=80,1", q, sr_illegal); end
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom); b = 8'($urandom) & ~a;
      tick();
      checks++; if (q !== m_q || sr_illegal !== 1'b1) begin failures++; $display("FAIL sr_sticky q=%h ill=%b exp=%h,1", q, sr_illegal, m_q); end
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (q !== 8'h00 || sr_illegal !== 1'b0 || chg !== m_chg) begin
      failures++; $display("FAIL sr_clr q=%h ill=%b chg=%b exp=00,0,%b", q, sr_illegal, chg, m_chg);
    end
  endtask

  task automatic test_enable_hold();
    en = 1'b1; mode = 2'd0; a = 8'h3C;
    tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mode = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
      tick();
      checks++; if (q !== 8'h3C || chg !== 1'b0) begin failures++; $display("FAIL en_hold q=%h chg=%b exp=3c,0", q, chg); end
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1; mode = 2'd0; a = 8'h5A;
    en1 = 1'b1; a1 = 1'b1;
    tick();
    en1 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (q !== 8'h00 || chg !== 1'b0 || q1 !== 1'b0) begin
      failures++; $display("FAIL async_reset q=%h chg=%b q1=%b exp=00,0,0", q, chg, q1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      clr  = ($urandom_range(0, 19) == 0);
      mode = 2'($urandom);
      a    = 8'($urandom);
      b    = 8'($urandom);
      tick();
      checks++; if (q !== m_q || qbar !== ~m_q) begin failures++; $display("FAIL rand_q i=%0d q=%h qbar=%h exp=%h", i, q, qbar, m_q); end
      checks++; if (chg !== m_chg || sr_illegal !== m_ill) begin
        failures++; $display("FAIL rand_flags i=%0d chg=%b ill=%b exp=%b,%b", i, chg, sr_illegal, m_chg, m_ill);
      end
`ifdef MMFF_TOGGLE_CNT_EN
      checks++; if (int'(toggle_cnt) != m_cnt) begin failures++; $display("FAIL rand_cnt i=%0d got=%0d exp=%0d", i, toggle_cnt, m_cnt); end
`endif
    end
    clr = 1'b0;
  endtask

`ifdef MMFF_TOGGLE_CNT_EN
  task automatic test_toggle_cnt();
    int exp_seq [0:4];
    exp_seq = '{1, 2, 3, 3, 3};
    en = 1'b1; clr = 1'b1; mode = 2'd0; a = 8'h00;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = (i % 2 == 0) ? 8'hFF : 8'h00;
      tick();
      checks++; if (int'(toggle_cnt) != exp_seq[i]) begin failures++; $display("FAIL cnt_sat step=%0d got=%0d exp=%0d", i, toggle_cnt, exp_seq[i]); end
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (toggle_cnt !== 2'd0) begin failures++; $display("FAIL cnt_clr got=%0d exp=0", toggle_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_legacy_t();
    test_d_mode();
    test_jk();
    test_sr_illegal();
    test_enable_hold();
    test_async_reset();
    test_random();
`ifdef MMFF_TOGGLE_CNT_EN
    test_toggle_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multimode_ff_bank.md
Name: multimode_ff_bank

Overview:
- Parametrised successor to the single-bit toggle flip-flop: a WIDTH-bit bank of flip-flops sharing one clock.
- Run-time mode selects D, T, JK or SR next-state logic for all bits.
- Provides complementary outputs, a change-detect pulse and a sticky SR-illegal flag.
- Used as the generic storage/toggle element under counters, dividers and small FSM experiments in the same design.

Parameters:
- WIDTH, 8, number of flip-flop bits in the bank (1..64).
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset and on synchronous clear.
- CNT_W, 16, width of the change counter (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  clock enable; when 0, all flops hold.
- clr  input  1  synchronous clear to RESET_VAL; overrides en and mode.
- mode  input  2  next-state function select (encoding below).
- a  input  WIDTH  D data / T toggle / J / S per bit, depending on mode.
- b  input  WIDTH  K / R per bit; ignored in D and T modes.
- q  output  WIDTH  registered state.
- qbar  output  WIDTH  always ~q (combinational).
- chg  output  1  registered pulse; 1 for the cycle after any bit of q changed.
- sr_illegal  output  1  sticky flag; set when SR mode sees S=R=1 on any bit with en=1.
- toggle_cnt  output  CNT_W  present only under MMFF_TOGGLE_CNT_EN.

Behaviour:
- Reset (rst_n=0, asynchronous): q=RESET_VAL, chg=0, sr_illegal=0, toggle_cnt=0. Deassertion is sampled at the next rising clk edge.
- Priority per rising edge: clr > en=0 (hold) > mode function.
- clr=1: q<=RESET_VAL, sr_illegal<=0, toggle_cnt<=0. chg follows the normal rule, so it is 1 if q actually changed.
- Mode functions, per bit i, when en=1 and clr=0:
  - MODE_D (2'b00): q[i]<=a[i].
  - MODE_T (2'b01): q[i]<=q[i]^a[i].
  - MODE_JK (2'b10): J=a, K=b. 00 hold, 01 reset, 10 set, 11 toggle.
  - MODE_SR (2'b11): S=a, R=b. 00 hold, 01 reset, 10 set, 11 hold and set sr_illegal<=1.
- Only the offending bit holds on S=R=1; the other bits update normally.
- sr_illegal stays set until clr or reset.
- Latency: q updates at the edge where the inputs are sampled, i.e. 1 cycle. qbar has zero additional latency.
- chg<=(q_next != q). It asserts for exactly one cycle per changing edge and stays high across consecutive changing edges.
- Mode change takes effect on the same edge it is sampled; no mode state is stored.
- Reset asserted mid-operation forces all state immediately, regardless of clk.
- WIDTH=1 must behave exactly like the original single-bit toggle flop when mode=MODE_T and a=t.

Optional Feature:
- Macro: MMFF_TOGGLE_CNT_EN.
- Defined: toggle_cnt port exists. Each edge with chg-next true increments toggle_cnt by 1, saturating at all-ones (no wrap). clr or reset zeroes it. An increment and a clr on the same edge: clr wins.
- Undefined: toggle_cnt port and counter logic are absent. All other behaviour is identical.

Decomposition:
- Package mmff_pkg holds:
  - localparams MODE_D, MODE_T, MODE_JK, MODE_SR (2-bit);
  - a typedef for the mode type;
  - a function next_bit(mode, q, a, b) returning the next bit value.
- One sub-module, mmff_bit_cell: single-bit next-state plus illegal detect, generated WIDTH times. The top level holds the registers, chg, the sticky flag and the counter.

Test Plan:
- T-mode legacy: WIDTH=1, mode=01, en=1. After reset, toggle a every 2 clocks → q sequence 0,0,1,1,0 matches the reference toggle model; qbar=~q every cycle.
- D mode: WIDTH=8, a=8'hA5 for 1 edge → q=8'hA5, chg=1 next cycle. Hold a=8'hA5 → chg=0.
- JK mode: q=8'h0F, a=8'hF0, b=8'hFF → q=8'hF0 (bits 0-3 reset, 4-7 toggled/set). Then a=b=8'hFF → q=8'h0F.
- SR illegal: q=8'h00, a=8'h81, b=8'h01 → q=8'h80, sr_illegal=1. Later clr=1 → q=RESET_VAL, sr_illegal=0.
- Enable/async reset: en=0 with changing a → q holds, chg=0. Drop rst_n mid-cycle → q=RESET_VAL before the next edge.
- MMFF_TOGGLE_CNT_EN: CNT_W=2, D mode with a alternating 00/FF for 5 edges → toggle_cnt 1,2,3,3,3 (saturates). clr → 0.
